pipe_controller: RTL and testbench

Pipelined successor to the single-cycle instruction decoder. Decodes the instruction in ID, carries the control bundle through ID/EX/MEM/WB registers, and drives hazard control: load-use and branch-operand stalls, ID and EX forwarding selects, and control-transfer flush. It sits beside the five-stage datapath and replaces the combinational controller.

---
 rtl/pipe_controller_pkg.sv | 72 +++++++
 rtl/pipe_controller_decode.sv | 113 +++++++++++
 rtl/pipe_controller.sv | 131 +++++++++++++
 tb/tb_pipe_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_controller_pkg.sv
// Shared definitions for the pipelined controller: instruction encodings,
// ALU / next-PC / forwarding codes, and the control bundle that rides the
// ID/EX/MEM/WB registers.
package pipe_controller_pkg;

  localparam int REG_AW_C   = 5;
  localparam int ALUCTR_W_C = 3;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // ALU operations
  localparam logic [ALUCTR_W_C-1:0] ALU_ADDU = 3'd0;
  localparam logic [ALUCTR_W_C-1:0] ALU_SUBU = 3'd1;
  localparam logic [ALUCTR_W_C-1:0] ALU_OR   = 3'd2;
  localparam logic [ALUCTR_W_C-1:0] ALU_LUI  = 3'd3;

  // Next-PC select
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BEQ = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // EX operand forwarding select
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [REG_AW_C-1:0] RA_REG = 5'd31;

  // Control bundle carried down the pipe; rs/rt ride along for EX forwarding.
  typedef struct packed {
    logic                  alu_src;
    logic [ALUCTR_W_C-1:0] alu_ctr;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  jal_pc;
    logic [REG_AW_C-1:0]   waddr;
    logic [REG_AW_C-1:0]   rs;
    logic [REG_AW_C-1:0]   rt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // A producer stage can supply src when it writes a non-zero register equal to src.
  function automatic logic fwd_match(input logic                wr,
                                     input logic [REG_AW_C-1:0] waddr,
                                     input logic [REG_AW_C-1:0] src);
    return wr && (waddr != '0) && (waddr == src);
  endfunction

  // EX operand select: MEM (non-load) result wins over WB result.
  function automatic logic [1:0] fwd_sel(input ctrl_t m, input ctrl_t w,
                                         input logic [REG_AW_C-1:0] src);
    if (fwd_match(m.reg_write && !m.mem_to_reg, m.waddr, src)) return FWD_MEM;
    if (fwd_match(w.reg_write, w.waddr, src))                   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_controller_decode.sv
// Combinational instruction decoder for the ID stage: produces the control
// bundle, immediate-extension controls, operand-use flags and transfer kind.
module pipe_decode
  import pipe_controller_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        ext_op_o,
  output logic        ext_high_o,
  output logic        use_rs_o,
  output logic        use_rt_o,
  output logic        is_beq_o,
  output logic        is_jal_o,
  output logic        is_jr_o
);

  logic [5:0]          op;
  logic [5:0]          funct;
  logic [REG_AW_C-1:0] rd;
  logic                unused_shamt;

  assign op           = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign rd           = instr_i[15:11];
  assign unused_shamt = ^instr_i[10:6];

  // Decode table; anything not listed stays a NOP with every enable low.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    ctrl_o     = CTRL_NOP;
    ctrl_o.rs  = instr_i[25:21];
    ctrl_o.rt  = instr_i[20:16];
    ext_op_o   = 1'b0;
    ext_high_o = 1'b0;
    use_rs_o   = 1'b0;
    use_rt_o   = 1'b0;
    is_beq_o   = 1'b0;
    is_jal_o   = 1'b0;
    is_jr_o    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.waddr     = rd;
            use_rs_o         = 1'b1;
            use_rt_o         = 1'b1;
          end
          FN_SUBU: begin
            ctrl_o.alu_ctr   = ALU_SUBU;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.waddr     = rd;
            use_rs_o         = 1'b1;
            use_rt_o         = 1'b1;
          end
          FN_JR: begin
            ctrl_o.waddr = rd;
            use_rs_o     = 1'b1;
            is_jr_o      = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctr   = ALU_OR;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.waddr     = ctrl_o.rt;
        use_rs_o         = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.waddr      = ctrl_o.rt;
        ext_op_o          = 1'b1;
        use_rs_o          = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.waddr     = ctrl_o.rt;
        ext_op_o         = 1'b1;
        use_rs_o         = 1'b1;
        use_rt_o         = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.waddr = ctrl_o.rt;
        ext_op_o     = 1'b1;
        use_rs_o     = 1'b1;
        use_rt_o     = 1'b1;
        is_beq_o     = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_ctr   = ALU_LUI;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.waddr     = ctrl_o.rt;
        ext_high_o       = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.jal_pc    = 1'b1;
        ctrl_o.waddr     = RA_REG;
        is_jal_o         = 1'b1;
      end
      default: ;
    endcase
    // $0 is hard-wired; never enable a write to it.
    if (ctrl_o.waddr == '0) ctrl_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_controller.sv
// Pipelined controller: ID decode, ID/EX/MEM/WB control registers, stall,
// forwarding and control-transfer flush logic for the five-stage datapath.
module pipe_controller
  import pipe_controller_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int ALUCTR_W   = 3,
  parameter int DELAY_SLOT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr_d,
  input  logic                br_eq_d,
  output logic [1:0]          npc_sel_d,
  output logic                ext_op_d,
  output logic                ext_high_d,
  output logic                fwd_rs_d,
  output logic                fwd_rt_d,
  output logic                alu_src_e,
  output logic [ALUCTR_W-1:0] alu_ctr_e,
  output logic [1:0]          fwd_a_e,
  output logic [1:0]          fwd_b_e,
  output logic                mem_write_m,
  output logic                reg_write_w,
  output logic                mem_to_reg_w,
  output logic                jal_pc_w,
  output logic [REG_AW-1:0]   waddr_w,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e
);

  localparam bit FLUSH_ON_TAKEN = (DELAY_SLOT == 0);

  ctrl_t               dec;
  ctrl_t               e_d, e_q, m_q, w_q;
  logic                use_rs, use_rt, is_beq, is_jal, is_jr;
  logic [REG_AW_C-1:0] rs_d, rt_d;
  logic                load_use, br_stall, stall, taken;
  logic                unused_w_bits;

  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

  pipe_decode u_decode (
    .instr_i    (instr_d),
    .ctrl_o     (dec),
    .ext_op_o   (ext_op_d),
    .ext_high_o (ext_high_d),
    .use_rs_o   (use_rs),
    .use_rt_o   (use_rt),
    .is_beq_o   (is_beq),
    .is_jal_o   (is_jal),
    .is_jr_o    (is_jr)
  );

  // Stall detection: load-use in EX, or an unresolved operand for an ID compare/jr.
  always_comb begin
    load_use = 1'b0;
    br_stall = 1'b0;
    if (e_q.mem_to_reg && (e_q.waddr != '0))
      load_use = (use_rs && (e_q.waddr == rs_d)) || (use_rt && (e_q.waddr == rt_d));
    if (is_beq || is_jr)
      br_stall =
        (use_rs && (fwd_match(e_q.reg_write, e_q.waddr, rs_d) ||
                    fwd_match(m_q.reg_write && m_q.mem_to_reg, m_q.waddr, rs_d))) ||
        (use_rt && (fwd_match(e_q.reg_write, e_q.waddr, rt_d) ||
                    fwd_match(m_q.reg_write && m_q.mem_to_reg, m_q.waddr, rt_d)));
  end

  assign stall   = load_use || br_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  // Next-PC select and taken-transfer flag; a stall holds the PC on pc+4.
  always_comb begin
    npc_sel_d = NPC_PC4;
    taken     = 1'b0;
    if (is_beq && br_eq_d) begin
      npc_sel_d = NPC_BEQ;
      taken     = 1'b1;
    end else if (is_jal) begin
      npc_sel_d = NPC_J;
      taken     = 1'b1;
    end else if (is_jr) begin
      npc_sel_d = NPC_JR;
      taken     = 1'b1;
    end
    if (stall) npc_sel_d = NPC_PC4;
  end

  // Stall dominates flush; nothing flushes while the pipe is held in reset.
  assign flush_d = FLUSH_ON_TAKEN && taken && !stall && rst_n;

  // Forwarding selects for the ID compare/jr operand and the EX ALU operands.
  always_comb begin
    fwd_rs_d = fwd_match(m_q.reg_write && !m_q.mem_to_reg, m_q.waddr, rs_d);
    fwd_rt_d = fwd_match(m_q.reg_write && !m_q.mem_to_reg, m_q.waddr, rt_d);
    fwd_a_e  = fwd_sel(m_q, w_q, e_q.rs);
    fwd_b_e  = fwd_sel(m_q, w_q, e_q.rt);
  end

  assign e_d = stall ? CTRL_NOP : dec;

  // ID/EX, EX/MEM and MEM/WB control registers; MEM and WB always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these registers are reset (unlike a RAM array) because the hazard outputs read them directly.
    if (!rst_n) begin
      e_q <= CTRL_NOP;
      m_q <= CTRL_NOP;
      w_q <= CTRL_NOP;
    end else begin
      // NOTE: non-blocking so every stage shifts from its pre-edge value on the same edge.
      e_q <= e_d;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  assign alu_src_e     = e_q.alu_src;
  assign alu_ctr_e     = e_q.alu_ctr;
  assign mem_write_m   = m_q.mem_write;
  assign reg_write_w   = w_q.reg_write;
  assign mem_to_reg_w  = w_q.mem_to_reg;
  assign jal_pc_w      = w_q.jal_pc;
  assign waddr_w       = w_q.waddr;
  assign unused_w_bits = ^{w_q.alu_src, w_q.alu_ctr, w_q.mem_write, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: a behavioural model tracks the
// instruction word held in each of EX/MEM/WB and derives every output from
// the ISA rules; two DUT copies cover both delay-slot settings.
module tb_pipe_controller;

  typedef enum int {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_JR} kind_e;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr_d = 32'h0;
  logic        br_eq_d = 1'b0;

  logic [1:0] d1_npc_sel_d, d0_npc_sel_d, d1_fwd_a_e, d0_fwd_a_e, d1_fwd_b_e, d0_fwd_b_e;
  logic       d1_ext_op_d, d0_ext_op_d, d1_ext_high_d, d0_ext_high_d;
  logic       d1_fwd_rs_d, d0_fwd_rs_d, d1_fwd_rt_d, d0_fwd_rt_d;
  logic       d1_alu_src_e, d0_alu_src_e;
  logic [2:0] d1_alu_ctr_e, d0_alu_ctr_e;
  logic       d1_mem_write_m, d0_mem_write_m, d1_reg_write_w, d0_reg_write_w;
  logic       d1_mem_to_reg_w, d0_mem_to_reg_w, d1_jal_pc_w, d0_jal_pc_w;
  logic [4:0] d1_waddr_w, d0_waddr_w;
  logic       d1_stall_f, d0_stall_f, d1_stall_d, d0_stall_d;
  logic       d1_flush_d, d0_flush_d, d1_flush_e, d0_flush_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: instruction word currently in EX, MEM, WB (0 = bubble).
  logic [31:0] st_e = 32'h0, st_m = 32'h0, st_w = 32'h0;

  pipe_controller #(.REG_AW(5), .ALUCTR_W(3), .DELAY_SLOT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .br_eq_d(br_eq_d),
    .npc_sel_d(d1_npc_sel_d), .ext_op_d(d1_ext_op_d), .ext_high_d(d1_ext_high_d),
    .fwd_rs_d(d1_fwd_rs_d), .fwd_rt_d(d1_fwd_rt_d), .alu_src_e(d1_alu_src_e),
    .alu_ctr_e(d1_alu_ctr_e), .fwd_a_e(d1_fwd_a_e), .fwd_b_e(d1_fwd_b_e),
    .mem_write_m(d1_mem_write_m), .reg_write_w(d1_reg_write_w), .mem_to_reg_w(d1_mem_to_reg_w),
    .jal_pc_w(d1_jal_pc_w), .waddr_w(d1_waddr_w), .stall_f(d1_stall_f), .stall_d(d1_stall_d),
    .flush_d(d1_flush_d), .flush_e(d1_flush_e)
  );

  pipe_controller #(.REG_AW(5), .ALUCTR_W(3), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .br_eq_d(br_eq_d),
    .npc_sel_d(d0_npc_sel_d), .ext_op_d(d0_ext_op_d), .ext_high_d(d0_ext_high_d),
    .fwd_rs_d(d0_fwd_rs_d), .fwd_rt_d(d0_fwd_rt_d), .alu_src_e(d0_alu_src_e),
    .alu_ctr_e(d0_alu_ctr_e), .fwd_a_e(d0_fwd_a_e), .fwd_b_e(d0_fwd_b_e),
    .mem_write_m(d0_mem_write_m), .reg_write_w(d0_reg_write_w), .mem_to_reg_w(d0_mem_to_reg_w),
    .jal_pc_w(d0_jal_pc_w), .waddr_w(d0_waddr_w), .stall_f(d0_stall_f), .stall_d(d0_stall_d),
    .flush_d(d0_flush_d), .flush_e(d0_flush_e)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic kind_e kind_of(input logic [31:0] i);
    case (i[31:26])
      6'h00: case (i[5:0])
               6'h21:   return K_ADDU;
               6'h23:   return K_SUBU;
               6'h08:   return K_JR;
               default: return K_NOP;
             endcase
      6'h0d:   return K_ORI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h0f:   return K_LUI;
      6'h03:   return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [4:0] dest(input logic [31:0] i);
    case (kind_of(i))
      K_NOP:                return 5'd0;
      K_ADDU, K_SUBU, K_JR: return i[15:11];
      K_JAL:                return 5'd31;
      default:              return i[20:16];
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] i);
    kind_e k = kind_of(i);
    return (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_LUI, K_JAL}) && (dest(i) != 5'd0);
  endfunction

  function automatic bit uses_rs(input kind_e k);
    return k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_JR};
  endfunction

  function automatic bit uses_rt(input kind_e k);
    return k inside {K_ADDU, K_SUBU, K_SW, K_BEQ};
  endfunction

  // Register r is not yet available to the ID compare.
  function automatic bit br_dep(input logic [4:0] r);
    return (writes(st_e) && dest(st_e) == r) ||
           (kind_of(st_m) == K_LW && writes(st_m) && dest(st_m) == r);
  endfunction

  function automatic bit m_stall();
    kind_e k = kind_of(instr_d);
    logic [4:0] rs = instr_d[25:21];
    logic [4:0] rt = instr_d[20:16];
    bit lu, br;
    lu = kind_of(st_e) == K_LW && dest(st_e) != 5'd0 &&
         ((uses_rs(k) && dest(st_e) == rs) || (uses_rt(k) && dest(st_e) == rt));
    br = (k == K_BEQ || k == K_JR) &&
         ((uses_rs(k) && br_dep(rs)) || (uses_rt(k) && br_dep(rt)));
    return lu || br;
  endfunction

  function automatic bit mem_fwd(input logic [4:0] r);
    return writes(st_m) && kind_of(st_m) != K_LW && dest(st_m) == r;
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [4:0] r);
    if (mem_fwd(r)) return 2'd2;
    if (writes(st_w) && dest(st_w) == r) return 2'd1;
    return 2'd0;
  endfunction

  // Model pipeline advance: bubble into EX on a stall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_e <= 32'h0;
      st_m <= 32'h0;
      st_w <= 32'h0;
    end else begin
      st_e <= m_stall() ? 32'h0 : instr_d;
      st_m <= st_e;
      st_w <= st_m;
    end
  end

  // Compare every output of both DUTs against the model on each falling edge.
  always @(negedge clk) begin : cmp
    kind_e      k, ke;
    logic       s, brt;
    logic [1:0] e_npc, e_fa, e_fb;
    logic [2:0] e_ctr;
    logic       e_src, e_fl0;
    logic [31:0] exp_vec;
    k   = kind_of(instr_d);
    ke  = kind_of(st_e);
    s   = m_stall();
    brt = (k == K_BEQ) && br_eq_d;
    e_npc = s ? 2'd0 : brt ? 2'd1 : (k == K_JAL) ? 2'd2 : (k == K_JR) ? 2'd3 : 2'd0;
    e_fl0 = (brt || k == K_JAL || k == K_JR) && !s && rst_n;
    e_fa  = fwd_exp(st_e[25:21]);
    e_fb  = fwd_exp(st_e[20:16]);
    e_src = ke inside {K_ORI, K_LW, K_SW, K_LUI};
    e_ctr = (ke == K_SUBU) ? 3'd1 : (ke == K_ORI) ? 3'd2 : (ke == K_LUI) ? 3'd3 : 3'd0;
    check("npc_sel_d", {30'd0, d1_npc_sel_d}, {30'd0, e_npc});
    check("ext_op_d", {31'd0, d1_ext_op_d}, {31'd0, k inside {K_LW, K_SW, K_BEQ}});
    check("ext_high_d", {31'd0, d1_ext_high_d}, {31'd0, k == K_LUI});
    check("fwd_rs_d", {31'd0, d1_fwd_rs_d}, {31'd0, mem_fwd(instr_d[25:21])});
    check("fwd_rt_d", {31'd0, d1_fwd_rt_d}, {31'd0, mem_fwd(instr_d[20:16])});
    check("alu_src_e", {31'd0, d1_alu_src_e}, {31'd0, e_src});
    check("alu_ctr_e", {29'd0, d1_alu_ctr_e}, {29'd0, e_ctr});
    check("fwd_a_e", {30'd0, d1_fwd_a_e}, {30'd0, e_fa});
    check("fwd_b_e", {30'd0, d1_fwd_b_e}, {30'd0, e_fb});
    check("mem_write_m", {31'd0, d1_mem_write_m}, {31'd0, kind_of(st_m) == K_SW});
    check("reg_write_w", {31'd0, d1_reg_write_w}, {31'd0, writes(st_w)});
    check("mem_to_reg_w", {31'd0, d1_mem_to_reg_w}, {31'd0, kind_of(st_w) == K_LW});
    check("jal_pc_w", {31'd0, d1_jal_pc_w}, {31'd0, kind_of(st_w) == K_JAL});
    check("waddr_w", {27'd0, d1_waddr_w}, {27'd0, dest(st_w)});
    check("stall_f/stall_d/flush_e", {29'd0, d1_stall_f, d1_stall_d, d1_flush_e}, {29'd0, s, s, s});
    check("flush_d ds1", {31'd0, d1_flush_d}, 32'd0);
    check("flush_d ds0", {31'd0, d0_flush_d}, {31'd0, e_fl0});
    exp_vec = {5'd0, e_npc, k inside {K_LW, K_SW, K_BEQ}, k == K_LUI, mem_fwd(instr_d[25:21]),
               mem_fwd(instr_d[20:16]), e_src, e_ctr, e_fa, e_fb, kind_of(st_m) == K_SW, writes(st_w),
               kind_of(st_w) == K_LW, kind_of(st_w) == K_JAL, dest(st_w), s, s, s};
    check("ds0 shared outputs",
          {5'd0, d0_npc_sel_d, d0_ext_op_d, d0_ext_high_d, d0_fwd_rs_d, d0_fwd_rt_d, d0_alu_src_e,
           d0_alu_ctr_e, d0_fwd_a_e, d0_fwd_b_e, d0_mem_write_m, d0_reg_write_w, d0_mem_to_reg_w,
           d0_jal_pc_w, d0_waddr_w, d0_stall_f, d0_stall_d, d0_flush_e}, exp_vec);
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  a, b, c;
    logic [15:0] imm;
    a   = 5'($urandom_range(0, 7));
    b   = 5'($urandom_range(0, 7));
    c   = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 10))
      0:       return r_type(6'h21, a, b, c);
      1:       return r_type(6'h23, a, b, c);
      2:       return i_type(6'h0d, a, b, imm);
      3:       return i_type(6'h23, a, b, imm);
      4:       return i_type(6'h2b, a, b, imm);
      5:       return i_type(6'h04, a, b, imm);
      6:       return i_type(6'h0f, 5'd0, b, imm);
      7:       return {6'h03, 26'($urandom)};
      8:       return r_type(6'h08, a, 5'd0, 5'd0);
      9:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic [31:0] i, input logic b);
    @(posedge clk);
    #1;
    instr_d = i;
    br_eq_d = b;
  endtask

  initial begin
    // Reset with ori $28,$0,0 sitting in ID.
    #1;
    rst_n   = 1'b0;
    instr_d = 32'h341c0000;
    repeat (2) @(negedge clk);
    #1;
    check("reset e/m/w outputs",
          {d1_alu_src_e, d1_alu_ctr_e, d1_fwd_a_e, d1_fwd_b_e, d1_mem_write_m, d1_reg_write_w,
           d1_mem_to_reg_w, d1_jal_pc_w, d1_waddr_w}, 32'd0);
    check("reset stall_f", {31'd0, d1_stall_f}, 32'd0);
    check("reset flush_e", {31'd0, d1_flush_e}, 32'd0);
    check("reset flush_d ds0", {31'd0, d0_flush_d}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 instr_d = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post-reset reg_write_w", {31'd0, d1_reg_write_w}, 32'd1);
    check("post-reset waddr_w", {27'd0, d1_waddr_w}, 32'd28);

    // Forwarding from MEM, then from WB.
    drive(r_type(6'h21, 5'd2, 5'd3, 5'd1), 1'b0);
    drive(r_type(6'h23, 5'd1, 5'd1, 5'd4), 1'b0);
    drive(32'h0, 1'b0);
    @(negedge clk);
    check("fwd_a_e from MEM", {30'd0, d1_fwd_a_e}, 32'd2);
    check("fwd_b_e from MEM", {30'd0, d1_fwd_b_e}, 32'd2);
    drive(r_type(6'h21, 5'd2, 5'd3, 5'd1), 1'b0);
    drive(32'h0, 1'b0);
    drive(r_type(6'h23, 5'd1, 5'd1, 5'd4), 1'b0);
    drive(32'h0, 1'b0);
    @(negedge clk);
    check("fwd_a_e from WB", {30'd0, d1_fwd_a_e}, 32'd1);
    check("fwd_b_e from WB", {30'd0, d1_fwd_b_e}, 32'd1);

    // Load-use: lw $5 then addu $6,$5,$0.
    drive(i_type(6'h23, 5'd0, 5'd5, 16'd0), 1'b0);
    drive(r_type(6'h21, 5'd5, 5'd0, 5'd6), 1'b0);
    @(negedge clk);
    check("load-use stall", {29'd0, d1_stall_f, d1_stall_d, d1_flush_e}, 32'd7);
    drive(r_type(6'h21, 5'd5, 5'd0, 5'd6), 1'b0);
    @(negedge clk);
    check("load-use released", {31'd0, d1_stall_f}, 32'd0);
    drive(32'h0, 1'b0);
    @(negedge clk);
    check("load-use fwd_a_e", {30'd0, d1_fwd_a_e}, 32'd1);

    // Branch stall: ori $7 then beq $7,$7 taken.
    drive(i_type(6'h0d, 5'd0, 5'd7, 16'd5), 1'b0);
    drive(i_type(6'h04, 5'd7, 5'd7, 16'd4), 1'b1);
    @(negedge clk);
    check("beq stall", {31'd0, d1_stall_f}, 32'd1);
    check("beq npc during stall", {30'd0, d1_npc_sel_d}, 32'd0);
    check("beq no flush while stalled", {31'd0, d0_flush_d}, 32'd0);
    drive(i_type(6'h04, 5'd7, 5'd7, 16'd4), 1'b1);
    @(negedge clk);
    check("beq npc_sel_d", {30'd0, d1_npc_sel_d}, 32'd1);
    check("beq fwd_rs/rt_d", {30'd0, d1_fwd_rs_d, d1_fwd_rt_d}, 32'd3);
    check("beq flush_d ds1", {31'd0, d1_flush_d}, 32'd0);
    check("beq flush_d ds0", {31'd0, d0_flush_d}, 32'd1);

    // jal.
    drive(32'h0, 1'b0);
    drive(32'h0c000c01, 1'b0);
    @(negedge clk);
    check("jal npc_sel_d", {30'd0, d1_npc_sel_d}, 32'd2);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    drive(32'h0, 1'b0);
    @(negedge clk);
    check("jal wb", {25'd0, d1_reg_write_w, d1_jal_pc_w, d1_waddr_w}, {25'd0, 2'b11, 5'd31});

    // Asynchronous reset in the middle of a load-use stall.
    drive(i_type(6'h23, 5'd0, 5'd5, 16'd0), 1'b0);
    drive(r_type(6'h21, 5'd5, 5'd0, 5'd6), 1'b0);
    @(negedge clk);
    #1;
    check("pre-reset stall", {31'd0, d1_stall_f}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-stall reset stall_f", {31'd0, d1_stall_f}, 32'd0);
    check("mid-stall reset e/m/w",
          {d1_alu_src_e, d1_alu_ctr_e, d1_mem_write_m, d1_reg_write_w, d1_mem_to_reg_w,
           d1_jal_pc_w, d1_waddr_w}, 32'd0);
    #2 rst_n = 1'b1;

    // Randomized traffic, holding ID while the model says the pipe stalls.
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      if (!m_stall()) instr_d = gen_instr();
      br_eq_d = 1'($urandom);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
